// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used by the serial adder datapath.
module full_adder (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic out,
  output logic Cout
);

  assign out  = Ain ^ Bin ^ Cin;
  assign Cout = (Ain & Bin) | (Cin & (Ain ^ Bin));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock with start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output ovf captured with sum.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_width_chk
    $error("serial_adder: WIDTH out of range");
  end

  sa_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  full_adder u_fa (
    .Ain  (a_sh[0]),
    .Bin  (b_sh[0]),
    .Cin  (carry),
    .out  (fa_s),
    .Cout (fa_c)
  );

  assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};
  assign last  = (count == CW'(WIDTH - 1));
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_nxt;
          carry <= fa_c;
          count <= count + 1'b1;
          // On the MSB bit the incoming carry is the carry into the MSB.
          if (last) begin
            sum   <= s_nxt;
            cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_c;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge and waits (bounded) for done; returns at the negedge where done is high.
  task automatic run_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output int lat, output int nbusy, output int nbad);
    logic [7:0] held;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    held = sum;
    @(negedge clk);
    start = 1'b0; a = 8'h5A; b = 8'hC3; cin = 1'b1;
    lat = 1; nbusy = 0; nbad = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (sum !== held) nbad++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, nbusy, nbad, ndone, dcnt;
    int dpos[3];
    logic [7:0] dsum[3];
    logic [7:0] lsum;

    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Basic add and timing
    run_add(8'h35, 8'h4A, 1'b0, lat, nbusy, nbad);
    chk("t1_latency", lat, 9);
    chk("t1_busy_cycles", nbusy, 8);
    chk("t1_no_partial", nbad, 0);
    chk("t1_sum", sum, 8'h7F);
    chk("t1_cout", cout, 0);
    chk("t1_busy_in_done", busy, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_sum_held", sum, 8'h7F);

    // Carry-out boundaries
    run_add(8'hFF, 8'h01, 1'b0, lat, nbusy, nbad);
    chk("t2a_sum", sum, 8'h00);
    chk("t2a_cout", cout, 1);
    run_add(8'hFF, 8'hFF, 1'b1, lat, nbusy, nbad);
    chk("t2b_sum", sum, 8'hFF);
    chk("t2b_cout", cout, 1);
    run_add(8'h80, 8'h80, 1'b0, lat, nbusy, nbad);
    chk("t2c_sum", sum, 8'h00);
    chk("t2c_cout", cout, 1);
    chk("t2c_no_partial", nbad, 0);

    // Start during RUN is ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; lsum = 8'hEE;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin ndone++; lsum = sum; end
      @(negedge clk);
    end
    chk("t3_done_count", ndone, 1);
    chk("t3_sum", lsum, 8'h30);
    chk("t3_idle", busy, 0);

    // Asynchronous reset mid-RUN
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_sum", sum, 0);
    chk("t4_cout", cout, 0);
    @(negedge clk);
    reset = 1'b1;
    run_add(8'h01, 8'h02, 1'b0, lat, nbusy, nbad);
    chk("t4_after_latency", lat, 9);
    chk("t4_after_sum", sum, 8'h03);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    dcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      if (done && dcnt < 3) begin dpos[dcnt] = i; dsum[dcnt] = sum; dcnt++; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("t5_done_count", dcnt, 3);
    if (dcnt == 3) begin
      chk("t5_pos0", dpos[0], 9);
      chk("t5_gap1", dpos[1] - dpos[0], 9);
      chk("t5_gap2", dpos[2] - dpos[1], 9);
      chk("t5_sum0", dsum[0], 8'h02);
      chk("t5_sum2", dsum[2], 8'h02);
    end
    lat = 0;
    while (busy && lat < 20) begin @(negedge clk); lat++; end
    chk("t5_drain", busy, 0);
    @(negedge clk);

    // Signed-overflow boundary
    run_add(8'h7F, 8'h01, 1'b0, lat, nbusy, nbad);
    chk("t6a_sum", sum, 8'h80);
    chk("t6a_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t6a_ovf", ovf, 1);
`endif
    run_add(8'hFF, 8'h01, 1'b0, lat, nbusy, nbad);
    chk("t6b_cout", cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t6b_ovf", ovf, 0);
`endif
    run_add(8'h80, 8'hFF, 1'b0, lat, nbusy, nbad);
    chk("t6c_sum", sum, 8'h7F);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t6c_ovf", ovf, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
